// File: rtl/serial_cmd_parser.sv
// Frames a UART byte stream into opcode + little-endian argument commands.
// Optional inter-byte timeout abort is built when CMD_TIMEOUT_EN is defined.
module serial_cmd_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  cmd,
   output logic [31:0] arg,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        busy,
   output logic        overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARG,
      S_HOLD
   } state_e;

   function automatic logic [2:0] arg_len(input logic [7:0] op);
      logic [2:0] len;
      case (op)
         8'h41:               len = 3'd2;
         8'h42:               len = 3'd1;
         8'h4f, 8'h4d, 8'h72: len = 3'd4;
         default:             len = 3'd0;
      endcase
      return len;
   endfunction

   state_e      state_q, state_d;
   logic [7:0]  op_q, op_d;
   logic [31:0] acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  need_q, need_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [31:0] arg_q, arg_d;
   logic        ovf_q, ovf_d;
   logic        take_op;
   logic [2:0]  op_len;
   logic [31:0] acc_n;

`ifdef CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   assign op_len = arg_len(rx_data);
   // acc is cleared on each opcode, so OR-ing the shifted byte places it
   assign acc_n  = acc_q | ({24'd0, rx_data} << {cnt_q[1:0], 3'b000});

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      need_d  = need_q;
      cmd_d   = cmd_q;
      arg_d   = arg_q;
      ovf_d   = ovf_q;
      take_op = 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      unique case (state_q)
         S_IDLE: take_op = rx_valid;
         S_ARG: begin
            if (rx_valid) begin
               acc_d = acc_n;
               cnt_d = cnt_q + 3'd1;
`ifdef CMD_TIMEOUT_EN
               tmo_d = '0;
`endif
               if (cnt_q + 3'd1 == need_q) begin
                  state_d = S_HOLD;
                  cmd_d   = op_q;
                  arg_d   = acc_n;
               end
            end
`ifdef CMD_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_HOLD;
               cmd_d   = 8'hff;
               arg_d   = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
`endif
         end
         S_HOLD: begin
            if (cmd_ready) begin
               if (rx_valid) take_op = 1'b1;
               else          state_d = S_IDLE;
            end else if (rx_valid) begin
               ovf_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (take_op) begin
         op_d   = rx_data;
         acc_d  = '0;
         cnt_d  = '0;
         need_d = op_len;
`ifdef CMD_TIMEOUT_EN
         tmo_d  = '0;
`endif
         if (op_len == 3'd0) begin
            state_d = S_HOLD;
            cmd_d   = rx_data;
            arg_d   = '0;
         end else begin
            state_d = S_ARG;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         need_q  <= '0;
         cmd_q   <= '0;
         arg_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         need_q  <= need_d;
         cmd_q   <= cmd_d;
         arg_q   <= arg_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef CMD_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= tmo_d;
   end
`endif

   assign cmd       = cmd_q;
   assign arg       = arg_q;
   assign cmd_valid = (state_q == S_HOLD);
   assign busy      = (state_q != S_IDLE);
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_cmd_parser.sv
// Scoreboard bench for serial_cmd_parser: expected frames are queued by the
// stimulus and popped by a monitor on every cmd_valid & cmd_ready handshake.
module tb_serial_cmd_parser;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  cmd;
   logic [31:0] arg;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        busy;
   logic        overflow;

   int checks   = 0;
   int failures = 0;
   logic [39:0] exp_q[$];

   always #5 clk = ~clk;

   serial_cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .cmd       (cmd),
      .arg       (arg),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .busy      (busy),
      .overflow  (overflow)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_frame(input logic [7:0] c, input logic [31:0] a);
      exp_q.push_back({c, a});
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // monitor: each handshake must match the oldest queued frame
   always @(negedge clk) begin
      logic [39:0] e;
      if (!rst && cmd_valid && cmd_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got cmd=%h arg=%h with empty queue",
                     cmd, arg);
         end else begin
            e = exp_q.pop_front();
            if ({cmd, arg} !== e) begin
               failures++;
               $display("FAIL sb_frame: got cmd=%h arg=%h expected cmd=%h arg=%h",
                        cmd, arg, e[39:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      cmd_ready = 1'b1;
      idle(2);
      rst = 1'b0;
      chk("rst_cmd", {24'd0, cmd}, 32'h0);
      chk("rst_arg", arg, 32'h0);
      chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);

      // zero-arg opcode: valid one cycle after byte, for one cycle
      expect_frame(8'h49, 32'h0);
      send(8'h49);
      chk("I_valid", {31'd0, cmd_valid}, 32'd1);
      chk("I_busy", {31'd0, busy}, 32'd1);
      idle(1);
      chk("I_valid_drop", {31'd0, cmd_valid}, 32'd0);
      chk("I_busy_drop", {31'd0, busy}, 32'd0);

      // little-endian 4-byte argument
      expect_frame(8'h4d, 32'h12345678);
      send(8'h4d); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      idle(1);

      // zero-extension
      expect_frame(8'h41, 32'h00001234);
      send(8'h41); send(8'h34); send(8'h12);
      idle(1);
      expect_frame(8'h42, 32'h000000ab);
      send(8'h42); send(8'hab);
      idle(1);

      // backpressure: byte dropped, overflow set, frame held
      cmd_ready = 1'b0;
      expect_frame(8'h63, 32'h0);
      send(8'h63);
      send(8'h54);
      chk("bp_ovf", {31'd0, overflow}, 32'd1);
      chk("bp_cmd", {24'd0, cmd}, 32'h63);
      chk("bp_valid", {31'd0, cmd_valid}, 32'd1);
      idle(2);
      chk("bp_cmd_hold", {24'd0, cmd}, 32'h63);

      // handshake with a new opcode on the same edge
      cmd_ready = 1'b1;
      expect_frame(8'h51, 32'h0);
      send(8'h51);
      idle(1);

      // sustained rate: one 1-byte command every 2 cycles
      expect_frame(8'h42, 32'h01);
      expect_frame(8'h42, 32'h02);
      send(8'h42); send(8'h01); send(8'h42); send(8'h02);
      idle(1);

`ifdef CMD_TIMEOUT_EN
      expect_frame(8'hff, 32'h0);
      send(8'h4f); send(8'h01);
      idle(15);
      chk("tmo_before", {31'd0, cmd_valid}, 32'd0);
      idle(1);
      chk("tmo_valid", {31'd0, cmd_valid}, 32'd1);
      chk("tmo_cmd", {24'd0, cmd}, 32'hff);
      idle(1);

      expect_frame(8'h4f, 32'h04030201);
      send(8'h4f); send(8'h01);
      idle(15);
      send(8'h02);
      chk("tmo_race", {31'd0, cmd_valid}, 32'd0);
      send(8'h03); send(8'h04);
      idle(1);
`else
      expect_frame(8'h4f, 32'h04030201);
      send(8'h4f); send(8'h01);
      idle(40);
      chk("wait_valid", {31'd0, cmd_valid}, 32'd0);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      send(8'h02); send(8'h03); send(8'h04);
      idle(1);
`endif

      // reset mid-frame
      send(8'h4d); send(8'h11); send(8'h22);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("mrst_cmd", {24'd0, cmd}, 32'h0);
      chk("mrst_arg", arg, 32'h0);
      chk("mrst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_ovf", {31'd0, overflow}, 32'd0);
      expect_frame(8'h4e, 32'h0);
      send(8'h4e);
      idle(3);

      chk("sb_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
